counter_ud_arb: RTL and testbench



---
 rtl/counter_ud_arb.sv | 136 +++++++++++++
 tb/tb_counter_ud_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ud_arb.sv
// Round-robin sequencer sharing one external up/down counter between NREQ requesters.
// Optional macro COUNTER_UD_ARB_SAT_EN: saturate at all-ones/zero instead of wrapping, flagged on sat.
module counter_ud_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_arg,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        result,
  output logic                    sat,
  output logic [WIDTH-1:0]        cnt_load,
  output logic                    cnt_load_en,
  output logic                    cnt_down,
  input  logic [WIDTH-1:0]        cnt_count,
  input  logic                    cnt_rollover
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef COUNTER_UD_ARB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [1:0]       op;
  logic [WIDTH-1:0] arg;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] result_hold;
  logic             sat_reg;
  logic [IW-1:0]    win;
  logic             stop;
  logic             stepping;

  // Rotating priority: first requester after the last winner.
  always_comb begin
    win = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        win = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Saturation stop is evaluated before the step would be taken.
  assign stop = SAT_EN && (rem != '0) &&
                (((op == OP_UP) && cnt_rollover) || ((op == OP_DOWN) && (cnt_count == '0)));

  assign stepping = (state == EXEC) && ((op == OP_UP) || (op == OP_DOWN)) &&
                    (rem != '0) && !stop;

  always_comb begin
    cnt_load_en = 1'b1;
    cnt_load    = cnt_count;
    cnt_down    = 1'b0;
    if (state == EXEC && op == OP_LOAD) begin
      cnt_load = arg;
    end else if (stepping) begin
      cnt_load_en = 1'b0;
      cnt_down    = (op == OP_DOWN);
    end
  end

  // During DONE the counter is already holding the final value.
  assign result = (state == DONE) ? cnt_count : result_hold;
  assign sat    = sat_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ptr         <= IW'(NREQ - 1);
      idx         <= '0;
      op          <= '0;
      arg         <= '0;
      rem         <= '0;
      result_hold <= '0;
      sat_reg     <= 1'b0;
      gnt         <= '0;
      done        <= '0;
    end else begin
      gnt     <= '0;
      done    <= '0;
      sat_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            op    <= req_op[2*int'(win) +: 2];
            arg   <= req_arg[WIDTH*int'(win) +: WIDTH];
            rem   <= req_arg[WIDTH*int'(win) +: WIDTH];
            idx   <= win;
            ptr   <= win;
            gnt   <= ONE_HOT0 << win;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_LOAD || op == OP_READ || rem == '0) begin
            state <= DONE;
            done  <= ONE_HOT0 << idx;
          end else if (stop) begin
            state   <= DONE;
            done    <= ONE_HOT0 << idx;
            sat_reg <= 1'b1;
            rem     <= '0;
          end else begin
            rem <= rem - WIDTH'(1);
            if (rem == WIDTH'(1)) begin
              state <= DONE;
              done  <= ONE_HOT0 << idx;
            end
          end
        end
        DONE: begin
          result_hold <= cnt_count;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_ud_arb.sv
// Bench for counter_ud_arb: external up/down counter, transaction-level model, directed and random traffic.
// Expectations adapt to COUNTER_UD_ARB_SAT_EN when defined.
module tb_counter_ud_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef COUNTER_UD_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [2*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_arg = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [WIDTH-1:0]      result, cnt_load, cnt_count;
  logic                  sat, cnt_load_en, cnt_down, cnt_rollover;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ud_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_op(req_op), .req_arg(req_arg),
    .gnt(gnt), .done(done), .result(result), .sat(sat),
    .cnt_load(cnt_load), .cnt_load_en(cnt_load_en), .cnt_down(cnt_down),
    .cnt_count(cnt_count), .cnt_rollover(cnt_rollover)
  );

  // The shared counter: free-running up/down unless loaded.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)             cnt_count <= '0;
    else if (cnt_load_en)  cnt_count <= cnt_load;
    else if (cnt_down)     cnt_count <= cnt_count - 1'b1;
    else                   cnt_count <= cnt_count + 1'b1;
  end
  assign cnt_rollover = &cnt_count;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endfunction

  // Transaction-level model: each grant fixes a latency and a final value up front.
  int m_cyc, m_gnt_cyc, m_done_cyc, m_idle_cyc, m_idx, m_ptr, m_res, m_cval, m_i, m_n, m_op, m_lat;
  bit m_sat;
  logic [NREQ-1:0] m_eg, m_ed;

  always @(negedge clk) begin
    if (!rstn) begin
      m_cyc = 0; m_gnt_cyc = -1; m_done_cyc = -1; m_idle_cyc = 0;
      m_ptr = NREQ - 1; m_cval = 0; m_idx = 0; m_res = 0; m_sat = 0;
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_sat", sat, 0);
    end else begin
      m_cyc++;
      m_eg = (m_cyc == m_gnt_cyc)  ? (NREQ'(1) << m_idx) : '0;
      m_ed = (m_cyc == m_done_cyc) ? (NREQ'(1) << m_idx) : '0;
      chk("gnt", gnt, m_eg);
      chk("done", done, m_ed);
      if (m_cyc == m_done_cyc) begin
        chk("result", result, m_res);
        chk("sat", sat, m_sat);
        m_cval = m_res;
      end
      if (m_cyc >= m_idle_cyc || m_cyc == m_done_cyc) chk("count_hold", cnt_count, m_cval);
      if (m_cyc >= m_idle_cyc && req != '0) begin
        m_i = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (m_i < 0 && req[(m_ptr + k) % NREQ]) m_i = (m_ptr + k) % NREQ;
        end
        m_op  = int'(req_op[2*m_i +: 2]);
        m_n   = int'(req_arg[WIDTH*m_i +: WIDTH]);
        m_sat = 1'b0;
        m_lat = 2;
        case (m_op)
          0: m_res = m_n;
          3: m_res = m_cval;
          1: begin
            if (SAT && m_cval + m_n > MAXV) begin
              m_res = MAXV; m_sat = 1'b1; m_lat = MAXV - m_cval + 2;
            end else begin
              m_res = (m_cval + m_n) & MAXV;
              if (m_n > 0) m_lat = m_n + 1;
            end
          end
          default: begin
            if (SAT && m_n > m_cval) begin
              m_res = 0; m_sat = 1'b1; m_lat = m_cval + 2;
            end else begin
              m_res = (m_cval - m_n) & MAXV;
              if (m_n > 0) m_lat = m_n + 1;
            end
          end
        endcase
        m_ptr = m_i; m_idx = m_i;
        m_gnt_cyc  = m_cyc + 1;
        m_done_cyc = m_cyc + m_lat;
        m_idle_cyc = m_done_cyc + 1;
      end
    end
  end

  task automatic do_cmd(input int i, input int op, input int arg, input int exp_res,
                        input int exp_lat, input bit exp_sat);
    int n;
    bit seen;
    logic [1:0] opv;
    logic [WIDTH-1:0] argv;
    opv  = op[1:0];
    argv = arg[WIDTH-1:0];
    @(posedge clk); #1;
    req = '0;
    req[i] = 1'b1;
    req_op[2*i +: 2] = opv;
    req_arg[WIDTH*i +: WIDTH] = argv;
    @(negedge clk);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("d_gnt", gnt, 1 << i);
      if (done[i]) seen = 1'b1;
    end
    chk("d_seen", seen, 1);
    chk("d_latency", n, exp_lat);
    chk("d_result", result, exp_res);
    chk("d_sat", sat, exp_sat);
    $display("cmd req%0d op%0d arg %0h -> result %0h sat %0b after %0d", i, op, arg, result, sat, n);
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  int order[5];
  int cyc_at[5];
  int g, t;

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    do_cmd(0, 0, 9, 9, 2, 0);
    repeat (3) @(negedge clk);
    chk("load9_hold", cnt_count, 9);

    do_cmd(0, 0, 14, 14, 2, 0);
    do_cmd(1, 1, 3, SAT ? 15 : 1, SAT ? 3 : 4, SAT);

    do_cmd(0, 0, 5, 5, 2, 0);
    do_cmd(2, 2, 0, 5, 2, 0);
    do_cmd(3, 3, 0, 5, 2, 0);

    do_cmd(0, 0, 3, 3, 2, 0);
    do_cmd(1, 2, 5, SAT ? 0 : 14, SAT ? 5 : 6, SAT);

    // All four requesters reading continuously from reset.
    pulse_reset();
    req = '1;
    req_op = '1;
    g = 0; t = 0;
    while (g < 5 && t < 60) begin
      @(negedge clk);
      t++;
      if (gnt != '0) begin
        order[g] = $clog2(gnt);
        cyc_at[g] = t;
        $display("rr grant %0d to req%0d at cycle %0d", g, order[g], t);
        g++;
      end
    end
    chk("rr_count", g, 5);
    for (int k = 0; k < 5; k++) chk("rr_order", order[k], k % NREQ);
    for (int k = 1; k < 5; k++) chk("rr_gap", cyc_at[k] - cyc_at[k-1], 3);
    @(posedge clk); #1 req = '0;
    repeat (6) @(posedge clk);

    // Abort an UP 7 with reset; priority must restart at requester 0.
    #1;
    req[2] = 1'b1;
    req_op[5:4] = 2'b01;
    req_arg[11:8] = 4'd7;
    repeat (4) @(negedge clk);
    pulse_reset();
    req = 4'b1001;
    req_op = '1;
    g = 0; t = 0;
    while (g == 0 && t < 10) begin
      @(negedge clk);
      t++;
      if (gnt != '0) g = 1;
    end
    chk("rst_winner", gnt, 4'b0001);
    $display("after reset grant %b", gnt);
    @(posedge clk); #1 req = '0;
    repeat (4) @(posedge clk);

    // Random traffic with occasional single-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rstn = ($urandom_range(0, 299) != 0);
      req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      req_op = (2*NREQ)'($urandom);
      req_arg = (WIDTH*NREQ)'($urandom);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    req = '0;
    repeat (40) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
